cpu_pc: RTL and testbench

//   Program counter stage fed by cpu_jmp: ADDRESS_OUT drives JMP_ADDR here. PC_OUT addresses program memory.

---
 rtl/cpu_pc_pkg.sv | 11 +
 rtl/cpu_pc_ret_stack.sv | 45 ++++
 rtl/cpu_pc.sv | 108 ++++++++++
 tb/tb_cpu_pc.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pc_pkg.sv
// Shared constants for the program counter stage: PC action encodings and default width.
package cpu_pc_pkg;

  localparam int CPU_WIDTH = 8;

  localparam logic [1:0] PC_INC  = 2'd0;
  localparam logic [1:0] PC_JMP  = 2'd1;
  localparam logic [1:0] PC_CALL = 2'd2;
  localparam logic [1:0] PC_RET  = 2'd3;

endpackage

// File: rtl/cpu_pc_ret_stack.sv
// Return-address LIFO for cpu_pc. Pushes are ignored when full and pops when empty;
// only the pointer is reset, the entries are left as they are.
module cpu_ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [SPW-1:0]   sp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_idx;

  assign FULL   = (sp == SPW'(DEPTH));
  assign EMPTY  = (sp == '0);
  assign rd_idx = sp[AW-1:0] - AW'(1);
  assign DOUT   = mem[rd_idx];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sp <= '0;
    end else if (PUSH && !FULL) begin
      sp <= sp + SPW'(1);
    end else if (POP && !EMPTY) begin
      sp <= sp - SPW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (PUSH && !FULL) begin
      mem[sp[AW-1:0]] <= DIN;
    end
  end

endmodule

// File: rtl/cpu_pc.sv
// Program counter with increment/jump/call/return and a return-address stack.
// Optional `PC_HALT_ON_ERR_EN: a stack overflow/underflow freezes PC and stack until reset.
module cpu_pc
  import cpu_pc_pkg::*;
#(
  parameter int               WIDTH     = CPU_WIDTH,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             JMP,
  input  logic             CALL,
  input  logic             RET,
  input  logic [WIDTH-1:0] JMP_ADDR,
  output logic [WIDTH-1:0] PC_OUT,
  output logic             STACK_EMPTY,
  output logic             STACK_FULL,
  output logic             STACK_ERR,
  output logic             HALT
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] stk_dout;
  logic [1:0]       act;
  logic             stk_full;
  logic             stk_empty;
  logic             err_q;
  logic             halt_q;
  logic             err_evt;
  logic             adv;
  logic             push;
  logic             pop;

  assign pc_inc = pc_q + WIDTH'(1);

  always_comb begin
    act = PC_INC;
    if (RET)       act = PC_RET;
    else if (CALL) act = PC_CALL;
    else if (JMP)  act = PC_JMP;
  end

  assign err_evt = ((act == PC_CALL) && stk_full) || ((act == PC_RET) && stk_empty);
  assign adv     = EN && !halt_q;
  assign push    = adv && (act == PC_CALL);
  assign pop     = adv && (act == PC_RET);

  always_comb begin
    pc_d = pc_inc;
    case (act)
      PC_JMP:  pc_d = JMP_ADDR;
      PC_CALL: pc_d = JMP_ADDR;
      PC_RET:  pc_d = stk_empty ? pc_inc : stk_dout;
      default: pc_d = pc_inc;
    endcase
`ifdef PC_HALT_ON_ERR_EN
    // The faulting instruction does not retire: PC keeps its pre-error value.
    if (err_evt) pc_d = pc_q;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else if (adv) begin
      pc_q <= pc_d;
      if (err_evt) err_q <= 1'b1;
    end
  end

`ifdef PC_HALT_ON_ERR_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      halt_q <= 1'b0;
    end else if (adv && err_evt) begin
      halt_q <= 1'b1;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

  cpu_ret_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_stack (
    .CLK  (CLK),
    .RST_N(RST_N),
    .PUSH (push),
    .POP  (pop),
    .DIN  (pc_inc),
    .DOUT (stk_dout),
    .FULL (stk_full),
    .EMPTY(stk_empty)
  );

  assign PC_OUT      = pc_q;
  assign STACK_EMPTY = stk_empty;
  assign STACK_FULL  = stk_full;
  assign STACK_ERR   = err_q;
  assign HALT        = halt_q;

endmodule

// File: tb/tb_cpu_pc.sv
// Scoreboard bench for cpu_pc: directed scenarios then random stimulus against a queue-based model.
module tb_cpu_pc;

  localparam int DEPTH = 4;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       JMP;
  logic       CALL;
  logic       RET;
  logic [7:0] JMP_ADDR;
  logic [7:0] PC_OUT;
  logic       STACK_EMPTY;
  logic       STACK_FULL;
  logic       STACK_ERR;
  logic       HALT;

  typedef struct packed {
    logic [7:0] pc;
    logic       empty;
    logic       full;
    logic       err;
    logic       halt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  // reference model state
  int   m_pc;
  int   m_stk[$];
  bit   m_err;
  bit   m_halt;
  bit   halt_mode;

  cpu_pc #(.WIDTH(8), .DEPTH(DEPTH), .RESET_VEC(8'h00)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .JMP        (JMP),
    .CALL       (CALL),
    .RET        (RET),
    .JMP_ADDR   (JMP_ADDR),
    .PC_OUT     (PC_OUT),
    .STACK_EMPTY(STACK_EMPTY),
    .STACK_FULL (STACK_FULL),
    .STACK_ERR  (STACK_ERR),
    .HALT       (HALT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t model_view();
    exp_t e;
    e.pc    = 8'(m_pc);
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == DEPTH);
    e.err   = m_err;
    e.halt  = m_halt;
    return e;
  endfunction

  task automatic check_now(input string name);
    exp_t e;
    exp_t a;
    e = model_view();
    a = {PC_OUT, STACK_EMPTY, STACK_FULL, STACK_ERR, HALT};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got pc=%h e=%b f=%b err=%b halt=%b, want pc=%h e=%b f=%b err=%b halt=%b",
               name, a.pc, a.empty, a.full, a.err, a.halt, e.pc, e.empty, e.full, e.err, e.halt);
    end
  endtask

  // Monitor: one registered result per clock edge, compared just after the edge.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        exp_t a;
        e = exp_q.pop_front();
        a = {PC_OUT, STACK_EMPTY, STACK_FULL, STACK_ERR, HALT};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL step@%0t: got pc=%h e=%b f=%b err=%b halt=%b, want pc=%h e=%b f=%b err=%b halt=%b",
                   $time, a.pc, a.empty, a.full, a.err, a.halt, e.pc, e.empty, e.full, e.err, e.halt);
        end
      end
    end
  end

  task automatic model_reset();
    m_pc   = 0;
    m_stk  = {};
    m_err  = 0;
    m_halt = 0;
  endtask

  task automatic model_step(input bit en, input bit j, input bit c, input bit r, input int addr);
    if (!en || m_halt) return;
    if (r) begin
      if (m_stk.size() == 0) begin
        m_err = 1;
        if (halt_mode) m_halt = 1;
        else m_pc = (m_pc + 1) % 256;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (c) begin
      if (m_stk.size() == DEPTH) begin
        m_err = 1;
        if (halt_mode) m_halt = 1;
        else m_pc = addr;
      end else begin
        m_stk.push_back((m_pc + 1) % 256);
        m_pc = addr;
      end
    end else if (j) begin
      m_pc = addr;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endtask

  // Called at posedge+2: drive, predict, then advance past the next edge.
  task automatic step(input bit en, input bit j, input bit c, input bit r, input logic [7:0] addr);
    EN = en; JMP = j; CALL = c; RET = r; JMP_ADDR = addr;
    model_step(en, j, c, r, int'(addr));
    exp_q.push_back(model_view());
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset(input string name);
    EN = 0; JMP = 0; CALL = 0; RET = 0; JMP_ADDR = 8'h00;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_now(name);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef PC_HALT_ON_ERR_EN
    halt_mode = 1;
`else
    halt_mode = 0;
`endif
    EN = 0; JMP = 0; CALL = 0; RET = 0; JMP_ADDR = 8'h00;
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    check_now("reset_state");
    RST_N = 1'b1;

    repeat (3) step(1, 0, 0, 0, 8'h00);          // 01,02,03
    repeat (4) step(0, 0, 0, 0, 8'h00);          // stall at 03
    step(0, 1, 1, 1, 8'h99);                     // stall ignores commands
    step(1, 1, 0, 0, 8'hA7);                     // A7
    step(1, 0, 0, 0, 8'h00);                     // A8
    do_reset("mid_reset");

    step(1, 1, 0, 0, 8'h10);
    step(1, 0, 1, 0, 8'h40);                     // CALL -> 40, push 11
    step(1, 0, 0, 1, 8'h00);                     // RET -> 11
    step(1, 1, 1, 0, 8'h55);                     // CALL wins over JMP
    step(1, 1, 1, 1, 8'h66);                     // RET wins over all
    step(1, 1, 0, 0, 8'hFF);
    step(1, 0, 0, 0, 8'h00);                     // wrap to 00
    step(1, 0, 1, 0, 8'h80);
    step(1, 0, 1, 0, 8'h81);
    step(1, 0, 1, 0, 8'h82);
    step(1, 0, 1, 0, 8'h83);                     // full
    step(1, 0, 1, 0, 8'h20);                     // overflow
    step(1, 0, 0, 1, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    do_reset("reset_after_ovf");

    step(1, 1, 0, 0, 8'h30);
    step(1, 0, 0, 1, 8'h00);                     // underflow
    step(1, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h44);
    do_reset("reset_after_unf");

    for (int i = 0; i < 1500; i++) begin
      bit en;
      bit j;
      bit c;
      bit r;
      en = ($urandom_range(0, 9) != 0);
      j  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 4) == 0);
      step(en, j, c, r, 8'($urandom));
      if ((i % 200) == 199) do_reset("rand_reset");
    end

    EN = 0; JMP = 0; CALL = 0; RET = 0;
    repeat (3) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
